// File: rtl/phase_clock_divider.sv
// phase_clock_divider
//   Multi-channel decimation clock generator. Every channel divides clk by
//   2*R (R = decimation_ratio, 0 treated as 1) with 50% duty. Each channel
//   has its own enable and a start delay that is loaded on the rising edge
//   of delay_valid, giving programmable inter-channel phase offsets.
//
// Ports
//   clk              system clock, all logic on its rising edge
//   rst              synchronous active-high reset
//   decimation_ratio half-period in clk cycles (0 behaves as 1)
//   en               per-channel enable
//   delay            per-channel start delay, channel i at [i*W +: W]
//   delay_valid      load strobe, rising edge only
//   dec_clk          divided clocks
//   dec_stb          one-cycle strobe in the first high cycle of dec_clk
//   busy             channel is counting down its start delay
//
// state    | meaning
// ST_IDLE  | channel disabled, dec_clk held low
// ST_RUN   | dividing, counter runs 0..r_act-1 per half-period
// ST_DELAY | counting down the start delay, dec_clk held low

module phase_clock_divider #(
  parameter int W   = 8,
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     decimation_ratio,
  input  logic [NCH-1:0]   en,
  input  logic [NCH*W-1:0] delay,
  input  logic             delay_valid,
  output logic [NCH-1:0]   dec_clk,
  output logic [NCH-1:0]   dec_stb,
  output logic [NCH-1:0]   busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DELAY = 2'd2
  } state_t;

  state_t         state_q [NCH];
  state_t         state_d [NCH];
  logic [W-1:0]   cnt_q   [NCH];
  logic [W-1:0]   cnt_d   [NCH];
  logic [W-1:0]   ract_q  [NCH];
  logic [W-1:0]   ract_d  [NCH];
  logic [W-1:0]   dly_q   [NCH];
  logic [W-1:0]   dly_d   [NCH];
  logic [NCH-1:0] clk_q, clk_d;
  logic [NCH-1:0] stb_q, stb_d;
  logic           dv_prev_q;
  logic           load;
  logic [W-1:0]   r_eff;

  assign r_eff = (decimation_ratio == '0) ? W'(1) : decimation_ratio;
  assign load  = delay_valid & ~dv_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ract_d  = ract_q;
    dly_d   = dly_q;
    clk_d   = clk_q;
    stb_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!en[i]) begin
        // disable wins over a simultaneous load
        state_d[i] = ST_IDLE;
        clk_d[i]   = 1'b0;
        cnt_d[i]   = '0;
      end else if (load) begin
        clk_d[i] = 1'b0;
        cnt_d[i] = '0;
        if (delay[i*W +: W] == '0) begin
          state_d[i] = ST_RUN;
          ract_d[i]  = r_eff;
        end else begin
          state_d[i] = ST_DELAY;
          dly_d[i]   = delay[i*W +: W];
        end
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            state_d[i] = ST_RUN;
            cnt_d[i]   = '0;
            ract_d[i]  = r_eff;
            clk_d[i]   = 1'b0;
          end
          ST_RUN: begin
            // ratio is only re-sampled at a half-period boundary: no runts
            if (cnt_q[i] == ract_q[i] - W'(1)) begin
              cnt_d[i]  = '0;
              clk_d[i]  = ~clk_q[i];
              ract_d[i] = r_eff;
              stb_d[i]  = ~clk_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + W'(1);
            end
          end
          ST_DELAY: begin
            clk_d[i] = 1'b0;
            if (dly_q[i] == W'(1)) begin
              state_d[i] = ST_RUN;
              cnt_d[i]   = '0;
              ract_d[i]  = r_eff;
            end else begin
              dly_d[i] = dly_q[i] - W'(1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            clk_d[i]   = 1'b0;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        ract_q[i]  <= W'(1);
        dly_q[i]   <= '0;
      end
      clk_q     <= '0;
      stb_q     <= '0;
      dv_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ract_q    <= ract_d;
      dly_q     <= dly_d;
      clk_q     <= clk_d;
      stb_q     <= stb_d;
      dv_prev_q <= delay_valid;
    end
  end

  assign dec_clk = clk_q;
  assign dec_stb = stb_q;

  for (genvar g = 0; g < NCH; g++) begin : g_busy
    assign busy[g] = (state_q[g] == ST_DELAY);
  end

endmodule

// File: tb/tb_phase_clock_divider.sv
// Testbench for phase_clock_divider: directed scenarios with literal
// expectations, then randomized stimulus, all checked every cycle against
// an event-time model (each channel tracks the absolute edge of its next
// start or toggle).

module tb_phase_clock_divider;
  localparam int W   = 8;
  localparam int NCH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W-1:0]     ratio = 8'd5;
  logic [NCH-1:0]   en = '0;
  logic [NCH*W-1:0] delay = '0;
  logic             dv = 1'b0;
  logic [NCH-1:0]   dec_clk, dec_stb, busy;

  int vectors = 0;
  int miscompares = 0;

  phase_clock_divider #(.W(W), .NCH(NCH)) dut (
    .clk              (clk),
    .rst              (rst),
    .decimation_ratio (ratio),
    .en               (en),
    .delay            (delay),
    .delay_valid      (dv),
    .dec_clk          (dec_clk),
    .dec_stb          (dec_stb),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // behavioural model
  bit     m_valid = 1'b0;
  longint ed = 0;
  bit     m_prev;
  bit     m_act [NCH];
  bit     m_started [NCH];
  bit     m_lvl [NCH];
  bit     m_stb [NCH];
  longint m_next [NCH];
  longint m_start [NCH];

  always @(posedge clk) begin
    int r;
    int d;
    bit ld;
    logic [NCH-1:0] e_clk, e_stb, e_busy;
    r = (ratio == 0) ? 1 : int'(ratio);
    if (rst) begin
      m_valid = 1'b1;
      m_prev  = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_act[i] = 0; m_started[i] = 0; m_lvl[i] = 0; m_stb[i] = 0;
      end
    end else begin
      ld = dv && !m_prev;
      m_prev = dv;
      for (int i = 0; i < NCH; i++) begin
        d = int'(delay[i*W +: W]);
        m_stb[i] = 0;
        if (!en[i]) begin
          m_act[i] = 0; m_started[i] = 0; m_lvl[i] = 0;
        end else if (ld) begin
          m_act[i] = 1; m_lvl[i] = 0;
          if (d == 0) begin
            m_started[i] = 1; m_next[i] = ed + r;
          end else begin
            m_started[i] = 0; m_start[i] = ed + d;
          end
        end else if (!m_act[i]) begin
          m_act[i] = 1; m_started[i] = 1; m_lvl[i] = 0; m_next[i] = ed + r;
        end else if (!m_started[i]) begin
          if (ed == m_start[i]) begin
            m_started[i] = 1; m_next[i] = ed + r;
          end
        end else if (ed == m_next[i]) begin
          m_lvl[i] = !m_lvl[i];
          m_stb[i] = m_lvl[i];
          m_next[i] = ed + r;
        end
      end
    end
    ed++;
    #1;
    if (m_valid) begin
      for (int i = 0; i < NCH; i++) begin
        e_clk[i]  = m_lvl[i];
        e_stb[i]  = m_stb[i];
        e_busy[i] = m_act[i] && !m_started[i];
      end
      vectors++;
      if (dec_clk !== e_clk) begin
        miscompares++;
        $display("FAIL model_dec_clk edge %0d: got %b expected %b", ed - 1, dec_clk, e_clk);
      end
      vectors++;
      if (dec_stb !== e_stb) begin
        miscompares++;
        $display("FAIL model_dec_stb edge %0d: got %b expected %b", ed - 1, dec_stb, e_stb);
      end
      vectors++;
      if (busy !== e_busy) begin
        miscompares++;
        $display("FAIL model_busy edge %0d: got %b expected %b", ed - 1, busy, e_busy);
      end
    end
  end

  task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    // reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_clk", dec_clk, 4'b0000);
    check("idle_busy", busy, 4'b0000);

    // basic divide, R=5, ch0 enabled at edge 0
    en = 4'b0001;
    step(5);  check("div_e4_clk", dec_clk, 4'b0000);
    step(1);  check("div_e5_clk", dec_clk, 4'b0001);
              check("div_e5_stb", dec_stb, 4'b0001);
    step(1);  check("div_e6_stb", dec_stb, 4'b0000);
    step(4);  check("div_e10_clk", dec_clk, 4'b0000);
    step(5);  check("div_e15_clk", dec_clk, 4'b0001);

    // phase offsets {0,3,6,9}, R=4
    @(negedge clk);
    ratio = 8'd4; en = 4'hF; delay = {8'd9, 8'd6, 8'd3, 8'd0}; dv = 1'b1;
    step(1);  check("ph_k_busy", busy, 4'b1110);
    @(negedge clk); dv = 1'b0;
    step(3);  check("ph_k3_clk", dec_clk, 4'b0000);
    step(1);  check("ph_k4_clk", dec_clk, 4'b0001);
              check("ph_k4_busy", busy, 4'b1100);
    step(3);  check("ph_k7_clk", dec_clk, 4'b0011);
              check("ph_k7_busy", busy, 4'b1000);
    step(6);  check("ph_k13_clk", dec_clk, 4'b1101);
    repeat (20) @(negedge clk);

    // ratio change 5 -> 2 mid-half-period
    ratio = 8'd5; en = 4'b0001; delay = '0; dv = 1'b1;
    step(1);
    @(negedge clk); dv = 1'b0;
    step(2);
    @(negedge clk); ratio = 8'd2;
    step(3);  check("rc_k5_clk", dec_clk, 4'b0001);
    step(1);  check("rc_k6_clk", dec_clk, 4'b0001);
    step(1);  check("rc_k7_clk", dec_clk, 4'b0000);
    step(2);  check("rc_k9_clk", dec_clk, 4'b0001);
    @(negedge clk); ratio = 8'd0;
    repeat (12) @(negedge clk);

    // re-load mid-delay
    ratio = 8'd3; en = 4'b0011; delay = {8'd0, 8'd0, 8'd8, 8'd8}; dv = 1'b1;
    step(1);
    @(negedge clk); dv = 1'b0;
    step(3);
    @(negedge clk); delay = {8'd0, 8'd0, 8'd2, 8'd2}; dv = 1'b1;
    step(1);  check("rl_k_busy", busy, 4'b0011);
    @(negedge clk); dv = 1'b0;
    step(1);  check("rl_k1_busy", busy, 4'b0011);
    step(1);  check("rl_k2_busy", busy, 4'b0000);
    step(2);  check("rl_k4_clk", dec_clk, 4'b0000);
    step(1);  check("rl_k5_clk", dec_clk, 4'b0011);

    // en low at the same edge as a load
    @(negedge clk);
    en = 4'b0001; delay = {8'd0, 8'd0, 8'd0, 8'd1}; dv = 1'b1;
    step(1);  check("pri_clk", dec_clk, 4'b0000);
              check("pri_busy", busy, 4'b0001);
    @(negedge clk); dv = 1'b0;
    repeat (6) @(negedge clk);

    // delay_valid held high: one load only
    en = 4'b0001; delay = {8'd0, 8'd0, 8'd0, 8'd4}; dv = 1'b1;
    step(8);  check("hold_k7_clk", dec_clk, 4'b0001);
              check("hold_k7_busy", busy, 4'b0000);
    repeat (3) @(negedge clk);
    dv = 1'b0;
    repeat (6) @(negedge clk);

    // reset mid-operation, then cold start
    en = 4'hF; delay = {8'd7, 8'd0, 8'd4, 8'd5}; dv = 1'b1;
    @(negedge clk); dv = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    step(1);  check("rst_clk", dec_clk, 4'b0000);
              check("rst_stb", dec_stb, 4'b0000);
              check("rst_busy", busy, 4'b0000);
    @(negedge clk); rst = 1'b0; ratio = 8'd5;
    step(5);  check("cold_e4_clk", dec_clk, 4'b0000);
    step(1);  check("cold_e5_clk", dec_clk, 4'hF);
              check("cold_e5_stb", dec_stb, 4'hF);

    // randomized phase
    @(negedge clk);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) en = NCH'($urandom);
      if ($urandom_range(0, 29) == 0) ratio = W'($urandom_range(0, 7));
      for (int i = 0; i < NCH; i++) delay[i*W +: W] = W'($urandom_range(0, 10));
      dv  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0; dv = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
